// File: rtl/key_debounce_pkg.sv
// -----------------------------------------------------------------------------
// key_debounce_pkg
//   Shared definitions for the pushbutton conditioning path:
//   - key_state_t : FSM state encodings (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT)
//   - DEB_20MS    : default debounce window, 20 ms at 50 MHz
//   - LONG_1S     : default long-press threshold, 1 s at 50 MHz
//   - SYNC_IDLE   : level a raw active-low key input shows while released
// -----------------------------------------------------------------------------
package key_debounce_pkg;

  localparam int unsigned DEB_20MS = 1_000_000;
  localparam int unsigned LONG_1S  = 50_000_000;

  // KEY inputs on the DE2 are active-low, so "released" is a 1.
  localparam logic SYNC_IDLE = 1'b1;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

endpackage : key_debounce_pkg

// File: rtl/key_debounce_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchroniser for a single asynchronous board input. The reset
//   value is a parameter so the same cell serves active-low keys (reset to 1)
//   and active-high switches (reset to 0).
// Ports
//   clk  in  1  destination clock
//   rst  in  1  asynchronous, active-high reset
//   d    in  1  asynchronous input
//   q    out 1  synchronised output, two clk edges behind d
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  // NOTE: sequential state is always written with <= so every flop samples
  // the pre-edge value of its neighbours; with = the second stage would
  // collapse into the first and the metastability filter would vanish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= RESET_VAL;
      q  <= RESET_VAL;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule : sync_2ff

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//   Turns one raw, bouncing, active-low pushbutton into a clean debounced
//   level plus single-cycle press / release / long-press strobes and a toggle
//   that serves as the LED blinker's run enable.
// Parameters
//   DEBOUNCE_CYCLES  stable samples needed to accept an edge (>= 1)
//   LONG_CYCLES      held cycles after acceptance before long_pulse (>= 1)
// Ports
//   CLOCK_50       in   1  system clock, rising edge
//   RESET          in   1  asynchronous, active-high reset
//   KEY_N          in   1  raw pushbutton, 0 = pressed, asynchronous
//   pressed        out  1  debounced level, 1 while the button is held
//   press_pulse    out  1  one-cycle strobe on accepted press
//   release_pulse  out  1  one-cycle strobe on accepted release
//   long_pulse     out  1  one-cycle strobe, once per press, after LONG_CYCLES
//   toggle         out  1  flips on every accepted press
// -----------------------------------------------------------------------------
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEB_20MS,
  parameter int unsigned LONG_CYCLES     = LONG_1S
) (
  input  logic CLOCK_50,
  input  logic RESET,
  input  logic KEY_N,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic toggle
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  key_state_t        state;
  logic [CNT_W-1:0]  cnt;        // consecutive stable samples in a *_WAIT state
  logic [HOLD_W-1:0] hold;       // cycles held since the press was accepted
  logic              long_done;  // long_pulse already issued for this press
  logic              key_s;      // synchronised KEY_N

  logic in_hold;
  logic release_accept;
  logic long_fire;

  sync_2ff #(
    .RESET_VAL (SYNC_IDLE)
  ) u_sync (
    .clk (CLOCK_50),
    .rst (RESET),
    .d   (KEY_N),
    .q   (key_s)
  );

  // The hold timer keeps running through release bounce, so a press that
  // chatters on the way up still counts as one continuous hold.
  assign in_hold        = (state == PRESSED) || (state == RELEASE_WAIT);
  assign release_accept = (state == RELEASE_WAIT) && key_s && (cnt == CNT_LAST);

  // A release accepted in the same cycle the hold timer expires wins: the
  // press is over, and only one strobe may be high per cycle.
  assign long_fire = in_hold && !release_accept && !long_done && (hold == HOLD_LAST);

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state         <= IDLE;
      cnt           <= '0;
      hold          <= '0;
      long_done     <= 1'b0;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      toggle        <= 1'b0;
    end else begin
      // Strobes default low so each one lasts exactly one cycle.
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;

      // Saturating hold timer; restarted on press acceptance below.
      if (in_hold && (hold != HOLD_LAST)) begin
        hold <= hold + 1'b1;
      end

      if (long_fire) begin
        long_pulse <= 1'b1;
        long_done  <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (!key_s) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end

        PRESS_WAIT: begin
          if (key_s) begin
            // Bounce: the low level did not last, drop back silently.
            state     <= IDLE;
            cnt       <= '0;
            long_done <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state       <= PRESSED;
            cnt         <= '0;
            hold        <= '0;
            press_pulse <= 1'b1;
            pressed     <= 1'b1;
            toggle      <= ~toggle;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        PRESSED: begin
          if (key_s) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end

        RELEASE_WAIT: begin
          if (!key_s) begin
            // Bounce on the way up: still held, hold timer untouched.
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state         <= IDLE;
            cnt           <= '0;
            release_pulse <= 1'b1;
            pressed       <= 1'b0;
            long_done     <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule : key_debounce
